// File: rtl/seq_sched_if.sv
// Control/config/output bundle between the pattern scheduler and its controller.
interface seq_sched_if #(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 4,
  parameter int LOOP_W = 4
);
  localparam int AW = $clog2(DEPTH);

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [3:0]        cfg_val;
  logic [HOLD_W-1:0] cfg_hold;
  logic [AW-1:0]     seq_len;
  logic [LOOP_W-1:0] loops;
  logic              start;
  logic              abort;
  logic [3:0]        out;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic [AW-1:0]     step;

  modport master (
    output cfg_we, cfg_addr, cfg_val, cfg_hold, seq_len, loops, start, abort,
    input  out, out_valid, busy, done, step
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_val, cfg_hold, seq_len, loops, start, abort,
    output out, out_valid, busy, done, step
  );
endinterface

// File: rtl/seq_sched.sv
// Programmable pattern scheduler: walks a value/hold table for loops+1 passes,
// driving a registered 4-bit value, then pulses done for one cycle.
module seq_sched #(
  parameter int         DEPTH    = 8,
  parameter int         HOLD_W   = 4,
  parameter int         LOOP_W   = 4,
  parameter logic [3:0] IDLE_VAL = 4'd0
) (
  input logic        clk,
  input logic        rstn,
  seq_sched_if.slave bus
);
  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        tbl_val  [DEPTH];
  logic [HOLD_W-1:0] tbl_hold [DEPTH];
  logic [AW-1:0]     len_q, step_q, nxt_idx;
  logic [HOLD_W-1:0] hold_q;
  logic [LOOP_W-1:0] pass_q;
  logic [3:0]        out_q;
  logic              out_valid_q, busy_q, done_q;
  logic              accept, at_end, finish_run, tbl_wr;

  function automatic logic [AW-1:0] clamp_len(input logic [AW-1:0] l);
    return (l > LAST) ? LAST : l;
  endfunction

  always_comb begin
    accept     = (state_q == IDLE) && bus.start && !bus.abort;
    at_end     = (hold_q == '0) && (step_q == len_q);
    finish_run = (state_q == RUN) && !bus.abort && at_end && (pass_q == '0);
    nxt_idx    = at_end ? '0 : step_q + 1'b1;
    tbl_wr     = bus.cfg_we && (state_q != RUN) && (int'(bus.cfg_addr) < DEPTH);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (bus.abort) state_d = IDLE;
               else if (finish_run) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Table: writable whenever no run is in progress; a write coinciding with
  // an accepted start lands, but the first value was already read from the old entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_val[i]  <= '0;
        tbl_hold[i] <= '0;
      end
    end else if (tbl_wr) begin
      tbl_val[bus.cfg_addr]  <= bus.cfg_val;
      tbl_hold[bus.cfg_addr] <= bus.cfg_hold;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q       <= '0;
      step_q      <= '0;
      hold_q      <= '0;
      pass_q      <= '0;
      out_q       <= IDLE_VAL;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          len_q       <= clamp_len(bus.seq_len);
          pass_q      <= bus.loops;
          step_q      <= '0;
          out_q       <= tbl_val[0];
          hold_q      <= tbl_hold[0];
          out_valid_q <= 1'b1;
          busy_q      <= 1'b1;
        end
        RUN: begin
          if (bus.abort || finish_run) begin
            out_q       <= IDLE_VAL;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            step_q      <= '0;
            done_q      <= !bus.abort;
          end else if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else begin
            // Advance to the next entry, or wrap to entry 0 for another pass.
            if (at_end) pass_q <= pass_q - 1'b1;
            step_q <= nxt_idx;
            out_q  <= tbl_val[nxt_idx];
            hold_q <= tbl_hold[nxt_idx];
          end
        end
        DONE:    done_q <= 1'b0;
        default: done_q <= 1'b0;
      endcase
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step      = step_q;
endmodule

// File: tb/tb_seq_sched.sv
// Directed bench for seq_sched: table walk, loops, abort, ignored writes/starts,
// start-coincident write, length clamp on a 6-entry build and async reset.
module tb_seq_sched;
  localparam int AW = 3;

  logic clk, rstn;
  int   total = 0;
  int   bad   = 0;

  seq_sched_if #(.DEPTH(8), .HOLD_W(4), .LOOP_W(4)) bus ();
  seq_sched_if #(.DEPTH(6), .HOLD_W(4), .LOOP_W(4)) bus6 ();

  seq_sched #(.DEPTH(8), .HOLD_W(4), .LOOP_W(4), .IDLE_VAL(4'd0)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  seq_sched #(.DEPTH(6), .HOLD_W(4), .LOOP_W(4), .IDLE_VAL(4'd0)) dut6 (
    .clk(clk), .rstn(rstn), .bus(bus6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] t1_out  [4] = '{4'd1, 4'd2, 4'd2, 4'd3};
  logic [2:0] t1_step [4] = '{3'd0, 3'd1, 3'd1, 3'd2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int v, input int h);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = AW'(a);
    bus.cfg_val  = 4'(v);
    bus.cfg_hold = 4'(h);
    tick();
    bus.cfg_we   = 1'b0;
  endtask

  task automatic do_start(input int len, input int lp);
    bus.seq_len = AW'(len);
    bus.loops   = 4'(lp);
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  task automatic chk_t1_pass(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_out"},   bus.out,       t1_out[i]);
      chk({tag, "_step"},  bus.step,      t1_step[i]);
      chk({tag, "_busy"},  bus.busy,      1);
      chk({tag, "_valid"}, bus.out_valid, 1);
      chk({tag, "_nodone"}, bus.done,     0);
      tick();
    end
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"},  bus.done,      1);
    chk({tag, "_dbusy"}, bus.busy,      0);
    chk({tag, "_dval"},  bus.out_valid, 0);
    chk({tag, "_dout"},  bus.out,       0);
    tick();
    chk({tag, "_done_clr"}, bus.done, 0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_val = 0; bus.cfg_hold = 0;
    bus.seq_len = 0; bus.loops = 0; bus.start = 0; bus.abort = 0;
    bus6.cfg_we = 0; bus6.cfg_addr = 0; bus6.cfg_val = 0; bus6.cfg_hold = 0;
    bus6.seq_len = 0; bus6.loops = 0; bus6.start = 0; bus6.abort = 0;
    #3;
    chk("rst_out",   bus.out,       0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy",  bus.busy,      0);
    chk("rst_done",  bus.done,      0);
    chk("rst_step",  bus.step,      0);
    rstn = 1'b1;
    tick();

    wr(0, 1, 0); wr(1, 2, 1); wr(2, 3, 0);

    // start together with abort in IDLE is not accepted
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("sa_busy",  bus.busy,      0);
    chk("sa_valid", bus.out_valid, 0);

    // T1
    do_start(2, 0);
    chk_t1_pass("t1");
    chk_done("t1");

    // T2: three passes, single done
    do_start(2, 2);
    for (int p = 0; p < 3; p++) chk_t1_pass("t2");
    chk_done("t2");

    // T3: abort on 2nd busy cycle
    do_start(2, 0);
    chk("t3_c1", bus.out, 1);
    tick();
    chk("t3_c2", bus.out, 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t3_out",   bus.out,       0);
    chk("t3_valid", bus.out_valid, 0);
    chk("t3_busy",  bus.busy,      0);
    chk("t3_done",  bus.done,      0);
    chk("t3_step",  bus.step,      0);
    tick();
    chk("t3_done2", bus.done, 0);
    do_start(2, 0);
    chk_t1_pass("t3r");
    chk_done("t3r");

    // T4: write and start mid-run are ignored
    do_start(2, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin bus.cfg_we = 1; bus.cfg_addr = 0; bus.cfg_val = 9; bus.cfg_hold = 0; end
      if (i == 1) begin bus.cfg_we = 0; bus.start = 1; end
      if (i == 2) bus.start = 0;
      chk("t4_out",  bus.out,  t1_out[i]);
      chk("t4_step", bus.step, t1_step[i]);
      chk("t4_busy", bus.busy, 1);
      tick();
    end
    chk_done("t4");

    // write coinciding with start: first value old, wrap shows new; seq_len=0
    bus.cfg_we = 1; bus.cfg_addr = 0; bus.cfg_val = 9; bus.cfg_hold = 0;
    bus.seq_len = 0; bus.loops = 1; bus.start = 1;
    tick();
    bus.cfg_we = 0; bus.start = 0;
    chk("ws_first", bus.out,  1);
    chk("ws_step0", bus.step, 0);
    tick();
    chk("ws_wrap",  bus.out,  9);
    chk("ws_step1", bus.step, 0);
    tick();
    chk_done("ws");
    do_start(2, 0);
    chk("t4_rerun", bus.out, 9);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;

    // T5: 8 entries x hold 15 -> 128 busy cycles
    for (int i = 0; i < 8; i++) wr(i, i, 15);
    do_start(7, 0);
    for (int c = 0; c < 128; c++) begin
      chk("t5_out",  bus.out,  c / 16);
      chk("t5_step", bus.step, c / 16);
      chk("t5_busy", bus.busy, 1);
      tick();
    end
    chk_done("t5");

    // DEPTH=6 build: seq_len 7 clamps to last index 5
    bus6.seq_len = 3'd7; bus6.start = 1'b1;
    tick();
    bus6.start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("d6_step", bus6.step, c);
      chk("d6_busy", bus6.busy, 1);
      tick();
    end
    chk("d6_done", bus6.done, 1);
    chk("d6_idle", bus6.busy, 0);

    // T6: async reset mid-run
    do_start(7, 0);
    repeat (20) tick();
    chk("t6_pre", bus.busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_out",   bus.out,       0);
    chk("t6_valid", bus.out_valid, 0);
    chk("t6_busy",  bus.busy,      0);
    chk("t6_done",  bus.done,      0);
    chk("t6_step",  bus.step,      0);
    #2 rstn = 1'b1;
    tick();
    do_start(7, 0);
    for (int c = 0; c < 8; c++) begin
      chk("t6_rout",  bus.out,       0);
      chk("t6_rval",  bus.out_valid, 1);
      chk("t6_rstep", bus.step,      c);
      tick();
    end
    chk_done("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
